mem_arbiter: RTL and testbench

Shares the core's single memory port between the instruction-fetch path and the load/store path. Each side presents a valid/ready request and receives a one-cycle response pulse. The arbiter keeps one transaction outstanding at a time and drives a handshaked downstream memory port. It sits between IFU/LSU and the memory model. It replaces the direct, same-cycle fetch and data access of the single-cycle datapath, so the core can move to a multi-cycle flow.

---
 rtl/mem_arbiter.sv | 94 +++++++++
 tb/tb_mem_arbiter.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one downstream memory port between instruction fetch and load/store,
// keeping a single transaction in flight with a fair tie-break and a response timeout.
module mem_arbiter #(
    parameter int AW      = 64,
    parameter int DW      = 64,
    parameter int TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            if_req_valid,
    output logic            if_req_ready,
    input  logic [AW-1:0]   if_addr,
    output logic            if_resp_valid,
    output logic [DW-1:0]   if_rdata,
    output logic            if_resp_err,
    input  logic            ls_req_valid,
    output logic            ls_req_ready,
    input  logic [AW-1:0]   ls_addr,
    input  logic            ls_wen,
    input  logic [DW-1:0]   ls_wdata,
    input  logic [DW/8-1:0] ls_wmask,
    output logic            ls_resp_valid,
    output logic [DW-1:0]   ls_rdata,
    output logic            ls_resp_err,
    output logic            mem_req_valid,
    input  logic            mem_req_ready,
    output logic [AW-1:0]   mem_addr,
    output logic            mem_wen,
    output logic [DW-1:0]   mem_wdata,
    output logic [DW/8-1:0] mem_wmask,
    input  logic            mem_resp_valid,
    input  logic [DW-1:0]   mem_rdata
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;
    state_t state, state_nx;
    logic owner_ls, last_ls, grant_ls, grant_if, resp_done;
    logic [15:0] cnt;
    // On a tie the side that did not win last time gets the port
    always_comb begin
        state_nx = state;
        grant_ls = ls_req_valid && (!if_req_valid || !last_ls);
        grant_if = if_req_valid && !grant_ls;
        if_req_ready = (state == IDLE) && grant_if;
        ls_req_ready = (state == IDLE) && grant_ls;
        mem_req_valid = state == REQ;
        if_resp_valid = (state == RESP) && !owner_ls;
        ls_resp_valid = (state == RESP) && owner_ls;
        resp_done = mem_resp_valid || (cnt == 16'(TIMEOUT - 1));
        case (state)
            IDLE:    state_nx = (grant_if || grant_ls) ? REQ : IDLE;
            REQ:     state_nx = mem_req_ready ? WAIT : REQ;
            WAIT:    state_nx = resp_done ? RESP : WAIT;
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            owner_ls    <= 1'b0;
            last_ls     <= 1'b0;
            cnt         <= '0;
            mem_addr    <= '0;
            mem_wen     <= 1'b0;
            mem_wdata   <= '0;
            mem_wmask   <= '0;
            if_rdata    <= '0;
            if_resp_err <= 1'b0;
            ls_rdata    <= '0;
            ls_resp_err <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == IDLE && (grant_if || grant_ls)) begin
                owner_ls  <= grant_ls;
                last_ls   <= grant_ls;
                mem_addr  <= grant_ls ? ls_addr : if_addr;
                mem_wen   <= grant_ls && ls_wen;
                mem_wdata <= grant_ls ? ls_wdata : '0;
                mem_wmask <= grant_ls ? ls_wmask : '0;
            end
            if (state == REQ && mem_req_ready) cnt <= '0;
            if (state == WAIT) cnt <= cnt + 16'd1;
            // Each side keeps its last result so rdata/err stay put between pulses
            if (state == WAIT && resp_done) begin
                if (owner_ls) begin
                    ls_rdata    <= mem_resp_valid ? mem_rdata : '0;
                    ls_resp_err <= !mem_resp_valid;
                end else begin
                    if_rdata    <= mem_resp_valid ? mem_rdata : '0;
                    if_resp_err <= !mem_resp_valid;
                end
            end
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios plus random traffic checked against a transaction-level model.
module tb_mem_arbiter;
    localparam int TO = 4;
    logic clk = 1'b0, rst_n = 1'b0;
    logic if_req_valid = 0, if_req_ready, if_resp_valid, if_resp_err;
    logic [63:0] if_addr = '0, if_rdata;
    logic ls_req_valid = 0, ls_req_ready, ls_wen = 0, ls_resp_valid, ls_resp_err;
    logic [63:0] ls_addr = '0, ls_wdata = '0, ls_rdata;
    logic [7:0] ls_wmask = '0, mem_wmask;
    logic mem_req_valid, mem_req_ready = 0, mem_wen, mem_resp_valid = 0;
    logic [63:0] mem_addr, mem_wdata, mem_rdata = '0;

    mem_arbiter #(.AW(64), .DW(64), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_addr(if_addr),
        .if_resp_valid(if_resp_valid), .if_rdata(if_rdata), .if_resp_err(if_resp_err),
        .ls_req_valid(ls_req_valid), .ls_req_ready(ls_req_ready), .ls_addr(ls_addr),
        .ls_wen(ls_wen), .ls_wdata(ls_wdata), .ls_wmask(ls_wmask),
        .ls_resp_valid(ls_resp_valid), .ls_rdata(ls_rdata), .ls_resp_err(ls_resp_err),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
        .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int tests = 0, fails = 0, cyc = 0;
    // Transaction-level model: one pending record plus the cycle numbers at which it advances
    logic m_busy, m_pend, m_own_ls, m_last_ls, m_wen;
    int m_ws, m_ra;
    logic [63:0] m_addr, m_wdata, m_if_rd, m_ls_rd;
    logic [7:0] m_wmask;
    logic m_if_err, m_ls_err;
    logic s_if_rdy, s_ls_rdy, s_if_rv, s_ls_rv, s_mem_v, s_wen, s_if_err, s_ls_err;
    logic [63:0] s_addr, s_wdata, s_if_rd, s_ls_rd;
    logic [7:0] s_wmask;

    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
        tests++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s @cyc %0d: got %h want %h", n, cyc, a, e);
        end
    endtask

    task automatic mreset();
        m_busy = 0; m_pend = 0; m_ra = -1; m_ws = 0; m_last_ls = 0; m_own_ls = 0;
        m_addr = '0; m_wdata = '0; m_wmask = '0; m_wen = 0;
        m_if_rd = '0; m_ls_rd = '0; m_if_err = 0; m_ls_err = 0;
    endtask

    // Called just after a posedge with inputs already set for the coming cycle
    task automatic step();
        logic any, win_ls, rv;
        @(negedge clk);
        any = if_req_valid || ls_req_valid;
        win_ls = ls_req_valid && (!if_req_valid || !m_last_ls);
        rv = m_busy && (m_ra == cyc);
        chk("if_req_ready", if_req_ready, !m_busy && any && !win_ls);
        chk("ls_req_ready", ls_req_ready, !m_busy && win_ls);
        chk("mem_req_valid", mem_req_valid, m_busy && m_pend);
        if (m_busy && m_pend) begin
            chk("mem_addr", mem_addr, m_addr);
            chk("mem_wen", mem_wen, m_wen);
            chk("mem_wdata", mem_wdata, m_wdata);
            chk("mem_wmask", mem_wmask, m_wmask);
        end
        chk("if_resp_valid", if_resp_valid, rv && !m_own_ls);
        chk("ls_resp_valid", ls_resp_valid, rv && m_own_ls);
        chk("if_rdata", if_rdata, m_if_rd);
        chk("if_resp_err", if_resp_err, m_if_err);
        chk("ls_rdata", ls_rdata, m_ls_rd);
        chk("ls_resp_err", ls_resp_err, m_ls_err);
        s_if_rdy = if_req_ready; s_ls_rdy = ls_req_ready; s_if_rv = if_resp_valid;
        s_ls_rv = ls_resp_valid; s_mem_v = mem_req_valid; s_addr = mem_addr; s_wen = mem_wen;
        s_wdata = mem_wdata; s_wmask = mem_wmask; s_if_rd = if_rdata; s_ls_rd = ls_rdata;
        s_if_err = if_resp_err; s_ls_err = ls_resp_err;
        if (!m_busy) begin
            if (any) begin
                m_busy = 1; m_pend = 1; m_ra = -1;
                m_own_ls = win_ls; m_last_ls = win_ls;
                m_addr = win_ls ? ls_addr : if_addr;
                m_wen = win_ls && ls_wen;
                m_wdata = win_ls ? ls_wdata : '0;
                m_wmask = win_ls ? ls_wmask : '0;
            end
        end else if (m_pend) begin
            if (mem_req_ready) begin
                m_pend = 0;
                m_ws = cyc + 1;
            end
        end else if (m_ra < 0) begin
            if (mem_resp_valid || (cyc + 1 - m_ws == TO)) begin
                m_ra = cyc + 1;
                if (m_own_ls) begin
                    m_ls_rd = mem_resp_valid ? mem_rdata : '0;
                    m_ls_err = !mem_resp_valid;
                end else begin
                    m_if_rd = mem_resp_valid ? mem_rdata : '0;
                    m_if_err = !mem_resp_valid;
                end
            end
        end else if (cyc == m_ra) m_busy = 0;
        cyc++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        mreset();
        #12;
        chk("rst_mem_req_valid", mem_req_valid, 0);
        chk("rst_resp_valid", {if_resp_valid, ls_resp_valid}, 0);
        chk("rst_rdata", if_rdata | ls_rdata, 0);
        chk("rst_addr", mem_addr, 0);
        @(negedge clk) rst_n = 1;
        @(posedge clk); #1;

        // tie after reset: LSU, then IFU right after LSU's RESP, then LSU again
        if_req_valid = 1; ls_req_valid = 1; if_addr = 64'h100; ls_addr = 64'h200;
        mem_req_ready = 1; mem_resp_valid = 1; mem_rdata = 64'h55;
        step();
        chk("tie1_ls_ready", s_ls_rdy, 1);
        chk("tie1_if_ready", s_if_rdy, 0);
        repeat (3) step();
        step();
        chk("tie2_if_ready", s_if_rdy, 1);
        repeat (3) step();
        step();
        chk("tie3_ls_ready", s_ls_rdy, 1);
        if_req_valid = 0; ls_req_valid = 0;
        repeat (4) step();

        // lone fetch, minimum latency
        mem_resp_valid = 0; if_req_valid = 1; if_addr = 64'h8000_0000;
        step();
        chk("fetch_ready", s_if_rdy, 1);
        if_req_valid = 0;
        step();
        chk("fetch_mem_valid", s_mem_v, 1);
        chk("fetch_addr", s_addr, 64'h8000_0000);
        chk("fetch_wen", s_wen, 0);
        chk("fetch_wmask", s_wmask, 0);
        mem_resp_valid = 1; mem_rdata = 64'h413;
        step();
        mem_resp_valid = 0;
        step();
        chk("fetch_resp", s_if_rv, 1);
        chk("fetch_rdata", s_if_rd, 64'h413);
        chk("fetch_err", s_if_err, 0);
        step();

        // store held off by mem_req_ready for three cycles
        ls_req_valid = 1; ls_wen = 1; ls_addr = 64'h8000_1000;
        ls_wdata = 64'h1122_3344_5566_7788; ls_wmask = 8'h0F; mem_req_ready = 0;
        step();
        ls_req_valid = 0; ls_wen = 0; ls_wdata = '0; ls_wmask = '0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("st_valid", s_mem_v, 1);
            chk("st_addr", s_addr, 64'h8000_1000);
            chk("st_wdata", s_wdata, 64'h1122_3344_5566_7788);
            chk("st_wmask", s_wmask, 8'h0F);
            chk("st_wen", s_wen, 1);
        end
        mem_req_ready = 1;
        step();
        chk("st_hs_valid", s_mem_v, 1);
        mem_req_ready = 0; mem_resp_valid = 1; mem_rdata = 64'hCAFE;
        step();
        mem_resp_valid = 0;
        step();
        chk("st_resp", s_ls_rv, 1);
        chk("st_rdata", s_ls_rd, 64'hCAFE);
        step();
        chk("st_resp_once", s_ls_rv, 0);

        // timeout: no response from memory
        ls_req_valid = 1; ls_addr = 64'h8000_2000; mem_req_ready = 1;
        step();
        ls_req_valid = 0;
        step();
        mem_req_ready = 0;
        repeat (TO) step();
        step();
        chk("to_resp", s_ls_rv, 1);
        chk("to_err", s_ls_err, 1);
        chk("to_rdata", s_ls_rd, 0);
        mem_resp_valid = 1;
        step();
        chk("to_stray", s_ls_rv, 0);
        mem_resp_valid = 0;
        step();
        chk("to_stray2", s_ls_rv | s_if_rv, 0);

        // reset while in WAIT
        ls_req_valid = 1; ls_addr = 64'h8000_3000; mem_req_ready = 1;
        step();
        ls_req_valid = 0;
        step();
        mem_req_ready = 0;
        step();
        #2 rst_n = 0;
        #1;
        chk("arst_mem_valid", mem_req_valid, 0);
        chk("arst_addr", mem_addr, 0);
        chk("arst_resp", {if_resp_valid, ls_resp_valid}, 0);
        chk("arst_err", {if_resp_err, ls_resp_err}, 0);
        chk("arst_rdata", if_rdata | ls_rdata, 0);
        mem_resp_valid = 1;
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1;
        mreset();
        @(posedge clk); #1;
        repeat (3) step();
        chk("arst_no_pulse", s_ls_rv | s_if_rv, 0);
        if_req_valid = 1; ls_req_valid = 1;
        step();
        chk("arst_tie_ls", s_ls_rdy, 1);
        if_req_valid = 0; ls_req_valid = 0; mem_resp_valid = 0;

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            if_req_valid = ($urandom_range(0, 2) != 0);
            ls_req_valid = ($urandom_range(0, 2) != 0);
            if_addr = {$urandom, $urandom};
            ls_addr = {$urandom, $urandom};
            ls_wen = $urandom_range(0, 1) == 1;
            ls_wdata = {$urandom, $urandom};
            ls_wmask = 8'($urandom);
            mem_req_ready = $urandom_range(0, 1) == 1;
            mem_resp_valid = $urandom_range(0, 3) == 0;
            mem_rdata = {$urandom, $urandom};
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
